// File: rtl/zstd_pkg.sv
// rtl/zstd_pkg.sv - shared types, constants and frame-header length helper
package zstd_pkg;

    localparam logic [15:0] ZSTD_MAGIC_LO = 16'hB528;
    localparam logic [15:0] ZSTD_MAGIC_HI = 16'hFD2F;

    typedef enum logic [1:0] {
        BLK_RAW        = 2'd0,
        BLK_RLE        = 2'd1,
        BLK_COMPRESSED = 2'd2,
        BLK_RESERVED   = 2'd3
    } blk_type_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_BAD_MAGIC    = 3'd1,
        ERR_HDR_TIMEOUT  = 3'd2,
        ERR_RESERVED_BLK = 3'd3,
        ERR_OVERSIZE     = 3'd4
    } err_code_e;

    typedef enum logic [3:0] {
        S_IDLE, S_MAGIC, S_HDR, S_HDR_WAIT, S_BHDR, S_PAYLOAD, S_CHK, S_DONE, S_ERR
    } seq_state_e;

    // Bytes in the frame header including the descriptor byte itself.
    function automatic logic [3:0] fhd_header_len(input logic [7:0] fhd);
        logic [3:0] did_sz;
        logic [3:0] fcs_sz;
        case (fhd[1:0])
            2'd0:    did_sz = 4'd0;
            2'd1:    did_sz = 4'd1;
            2'd2:    did_sz = 4'd2;
            default: did_sz = 4'd4;
        endcase
        case (fhd[7:6])
            2'd0:    fcs_sz = fhd[5] ? 4'd1 : 4'd0;
            2'd1:    fcs_sz = 4'd2;
            2'd2:    fcs_sz = 4'd4;
            default: fcs_sz = 4'd8;
        endcase
        return 4'd1 + {3'd0, ~fhd[5]} + did_sz + fcs_sz;
    endfunction

endpackage

// File: rtl/zstd_frame_sequencer_if.sv
// rtl/zstd_frame_sequencer_if.sv - stream, parser and block-decoder signals of the frame sequencer
interface zstd_frame_sequencer_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        hp_start;
    logic [15:0] hp_data;
    logic        hp_finished;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        blk_valid;
    logic        blk_ready;
    logic [1:0]  blk_type;
    logic [20:0] blk_size;
    logic        blk_last;
    logic        chk_valid;
    logic [31:0] chk_value;
    logic        frame_done;
    logic        error;
    logic [2:0]  err_code;

    modport master (
        input  in_data, in_valid, hp_finished, out_ready, blk_ready,
        output in_ready, hp_start, hp_data, out_byte, out_valid, blk_valid, blk_type,
               blk_size, blk_last, chk_valid, chk_value, frame_done, error, err_code
    );

    modport slave (
        output in_data, in_valid, hp_finished, out_ready, blk_ready,
        input  in_ready, hp_start, hp_data, out_byte, out_valid, blk_valid, blk_type,
               blk_size, blk_last, chk_valid, chk_value, frame_done, error, err_code
    );
endinterface

// File: rtl/zstd_byte_unpacker.sv
// rtl/zstd_byte_unpacker.sv - 16-bit to byte unpacker with a one-byte residue
module zstd_byte_unpacker (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [7:0]  load_byte_i,
    input  logic        byte_req_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic [15:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o
);
    logic [7:0] res_q, res_d;
    logic       res_valid_q, res_valid_d;

    // A new word is only pulled when the residue cannot satisfy the request.
    assign word_ready_o = byte_req_i && !res_valid_q;
    assign byte_valid_o = byte_req_i && (res_valid_q || word_valid_i);
    assign byte_o       = res_valid_q ? res_q : word_i[7:0];

    always_comb begin
        res_d       = res_q;
        res_valid_d = res_valid_q;
        if (flush_i) begin
            res_valid_d = 1'b0;
        end else if (load_i) begin
            res_d       = load_byte_i;
            res_valid_d = 1'b1;
        end else if (byte_valid_o) begin
            if (res_valid_q) begin
                res_valid_d = 1'b0;
            end else begin
                res_d       = word_i[15:8];
                res_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end
endmodule

// File: rtl/zstd_frame_sequencer.sv
// rtl/zstd_frame_sequencer.sv - Zstandard frame controller: magic, header hand-off, block walk, checksum
module zstd_frame_sequencer
    import zstd_pkg::*;
#(
    parameter int MAX_BLOCK_SIZE = 131072,
    parameter int HDR_TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    zstd_frame_sequencer_if.master  bus
);
    seq_state_e  state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic [3:0]  hdr_len_q, hdr_len_d;
    logic        chk_flag_q, chk_flag_d;
    logic [23:0] h_q, h_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] chk_q, chk_d;
    logic        chk_valid_q, chk_valid_d;
    err_code_e   err_q, err_d;

    logic [7:0]  ub_byte;
    logic        ub_valid, ub_req, ub_word_ready, ub_flush, ub_load;
    logic        in_rdy, accept;
    logic [3:0]  hlen_now, hwords_now;
    logic [23:0] h_next;
    logic [20:0] n_bytes;
    seq_state_e  after_blk;

    zstd_byte_unpacker u_unpack (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (ub_flush),
        .load_i       (ub_load),
        .load_byte_i  (bus.in_data[15:8]),
        .byte_req_i   (ub_req),
        .byte_o       (ub_byte),
        .byte_valid_o (ub_valid),
        .word_i       (bus.in_data),
        .word_valid_i (bus.in_valid),
        .word_ready_o (ub_word_ready)
    );

    assign in_rdy     = (state_q == S_IDLE) || (state_q == S_MAGIC) || (state_q == S_HDR) || ub_word_ready;
    assign accept     = bus.in_valid && in_rdy;
    assign hlen_now   = (cnt_q == 21'd0) ? fhd_header_len(bus.in_data[7:0]) : hdr_len_q;
    assign hwords_now = 4'((5'(hlen_now) + 5'd1) >> 1);
    assign h_next     = {ub_byte, h_q[23:8]};
    assign n_bytes    = (h_q[2:1] == BLK_RLE) ? 21'd1 : h_q[23:3];
    assign after_blk  = !h_q[0] ? S_BHDR : (chk_flag_q ? S_CHK : S_DONE);

    always_comb begin
        ub_req = 1'b0;
        case (state_q)
            S_BHDR:    ub_req = (cnt_q < 21'd3);
            S_PAYLOAD: ub_req = (cnt_q != 21'd0) && (!out_valid_q || bus.out_ready);
            S_CHK:     ub_req = (cnt_q < 21'd4);
            default:   ub_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_len_d   = hdr_len_q;
        chk_flag_d  = chk_flag_q;
        h_d         = h_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        chk_d       = chk_q;
        chk_valid_d = 1'b0;
        err_d       = err_q;
        ub_flush    = 1'b0;
        ub_load     = 1'b0;
        case (state_q)
            S_IDLE, S_MAGIC: begin
                if (accept) begin
                    if (bus.in_data != ((state_q == S_IDLE) ? ZSTD_MAGIC_LO : ZSTD_MAGIC_HI)) begin
                        state_d = S_ERR;
                        err_d   = ERR_BAD_MAGIC;
                    end else begin
                        state_d = (state_q == S_IDLE) ? S_MAGIC : S_HDR;
                        cnt_d   = '0;
                    end
                end
            end
            S_HDR: begin
                if (accept) begin
                    cnt_d = cnt_q + 21'd1;
                    if (cnt_q == 21'd0) begin
                        hdr_len_d  = hlen_now;
                        chk_flag_d = bus.in_data[2];
                    end
                    // Odd header length leaves the first block-header byte in the upper half.
                    if (cnt_q[3:0] + 4'd1 == hwords_now) begin
                        ub_load = hlen_now[0];
                        state_d = S_HDR_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_HDR_WAIT: begin
                if (bus.hp_finished) begin
                    state_d = S_BHDR;
                    cnt_d   = '0;
                end else if (cnt_q == 21'(HDR_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    err_d   = ERR_HDR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            S_BHDR: begin
                if (cnt_q == 21'd3) begin
                    if (bus.blk_ready) begin
                        state_d = (n_bytes == 21'd0) ? after_blk : S_PAYLOAD;
                        cnt_d   = n_bytes;
                    end
                end else if (ub_valid) begin
                    h_d   = h_next;
                    cnt_d = cnt_q + 21'd1;
                    if (cnt_q == 21'd2) begin
                        if (h_next[2:1] == BLK_RESERVED) begin
                            state_d = S_ERR;
                            err_d   = ERR_RESERVED_BLK;
                        end else if (h_next[23:3] > 21'(MAX_BLOCK_SIZE)) begin
                            state_d = S_ERR;
                            err_d   = ERR_OVERSIZE;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (ub_valid) begin
                    out_byte_d  = ub_byte;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q - 21'd1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (cnt_q == 21'd0 && (!out_valid_q || bus.out_ready)) begin
                    out_valid_d = 1'b0;
                    state_d     = after_blk;
                end
            end
            S_CHK: begin
                if (ub_valid) begin
                    chk_d = {ub_byte, chk_q[31:8]};
                    cnt_d = cnt_q + 21'd1;
                    if (cnt_q == 21'd3) begin
                        chk_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ub_flush = 1'b1;
                cnt_d    = '0;
                state_d  = S_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hdr_len_q   <= '0;
            chk_flag_q  <= 1'b0;
            h_q         <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            chk_q       <= '0;
            chk_valid_q <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_len_q   <= hdr_len_d;
            chk_flag_q  <= chk_flag_d;
            h_q         <= h_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            chk_q       <= chk_d;
            chk_valid_q <= chk_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready   = in_rdy && !reset;
    assign bus.hp_start   = (state_q == S_HDR) && accept && (cnt_q == 21'd0);
    assign bus.hp_data    = (state_q == S_HDR) ? bus.in_data : 16'h0000;
    assign bus.out_byte   = out_byte_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.blk_valid  = (state_q == S_BHDR) && (cnt_q == 21'd3);
    assign bus.blk_type   = h_q[2:1];
    assign bus.blk_size   = h_q[23:3];
    assign bus.blk_last   = h_q[0];
    assign bus.chk_valid  = chk_valid_q;
    assign bus.chk_value  = chk_q;
    assign bus.frame_done = (state_q == S_DONE);
    assign bus.error      = (state_q == S_ERR);
    assign bus.err_code   = err_q;
endmodule

// File: tb/tb_zstd_frame_sequencer.sv
// tb/tb_zstd_frame_sequencer.sv - directed self-checking bench for zstd_frame_sequencer
module tb_zstd_frame_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    zstd_frame_sequencer_if bus ();

    zstd_frame_sequencer #(.MAX_BLOCK_SIZE(131072), .HDR_TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] wq[$];
    bit          acc;
    bit          hp_auto = 1'b1;
    bit          rand_rdy = 1'b0;

    logic [7:0]  got_bytes[$];
    int          hp_start_cnt, blk_cnt, chk_cnt, done_cnt;
    logic [15:0] hp_data_seen;
    logic [23:0] blk_seen;
    logic [31:0] chk_seen;

    logic [89:0] outs;
    assign outs = {bus.in_ready, bus.hp_start, bus.hp_data, bus.out_byte, bus.out_valid,
                   bus.blk_valid, bus.blk_type, bus.blk_size, bus.blk_last, bus.chk_valid,
                   bus.chk_value, bus.frame_done, bus.error, bus.err_code};

    initial begin
        forever begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready && !reset;
            if (!reset) begin
                if (bus.hp_start) begin
                    hp_start_cnt++;
                    hp_data_seen = bus.hp_data;
                end
                if (bus.out_valid && bus.out_ready) got_bytes.push_back(bus.out_byte);
                if (bus.blk_valid && bus.blk_ready) begin
                    blk_cnt++;
                    blk_seen = {bus.blk_size, bus.blk_type, bus.blk_last};
                end
                if (bus.chk_valid) begin
                    chk_cnt++;
                    chk_seen = bus.chk_value;
                end
                if (bus.frame_done) done_cnt++;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.out_ready = 1'b1;
        bus.blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (acc && wq.size() > 0) void'(wq.pop_front());
            bus.in_valid  = (wq.size() > 0) && !reset;
            bus.in_data   = (wq.size() > 0) ? wq[0] : 16'h0;
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.blk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        bus.hp_finished = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.hp_start && hp_auto && !reset) begin
                repeat (3) @(posedge clk);
                #1 bus.hp_finished = 1'b1;
                @(posedge clk);
                #1 bus.hp_finished = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        got_bytes.delete();
        hp_start_cnt = 0;
        blk_cnt      = 0;
        chk_cnt      = 0;
        done_cnt     = 0;
        hp_data_seen = '0;
        blk_seen     = '0;
        chk_seen     = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        wq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_big_frame();
        logic [7:0] bs[$];
        bs = '{8'h61, 8'h09, 8'h00};
        for (int i = 0; i < 300; i++) bs.push_back(8'((i * 37 + 11) % 256));
        if (bs.size() % 2 != 0) bs.push_back(8'h00);
        wq.push_back(16'hB528);
        wq.push_back(16'hFD2F);
        wq.push_back(16'h0520);
        for (int i = 0; i < bs.size(); i += 2) wq.push_back({bs[i + 1], bs[i]});
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (outs !== 90'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset = 1'b0;
        clear_mon();
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.error, bus.err_code} !== 5'b10000) begin
            errors++;
            $display("FAIL idle_after_reset: got in_ready/error/code %b expected 10000", {bus.in_ready, bus.error, bus.err_code});
        end
    endtask

    task automatic test_raw_frame();
        logic [7:0] exp_b [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        int bad = 0;
        clear_mon();
        wq = '{16'hB528, 16'hFD2F, 16'h0520, 16'h0029, 16'h4100, 16'h4342, 16'h4544};
        wait_done(200);
        checks++;
        if (hp_start_cnt !== 1 || hp_data_seen !== 16'h0520) begin
            errors++;
            $display("FAIL raw_hp_start: got count %0d data %h expected 1 / 0520", hp_start_cnt, hp_data_seen);
        end
        checks++;
        if (blk_cnt !== 1 || blk_seen !== {21'd5, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL raw_blk_info: got count %0d info %h expected 1 / %h", blk_cnt, blk_seen, {21'd5, 2'd0, 1'b1});
        end
        if (got_bytes.size() != 5) bad = 1;
        else for (int i = 0; i < 5; i++) if (got_bytes[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL raw_payload: got %0d bytes (%0d wrong) expected 41 42 43 44 45", got_bytes.size(), bad);
        end
        checks++;
        if (done_cnt !== 1 || chk_cnt !== 0 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL raw_done: got done %0d chk %0d error %b expected 1 / 0 / 0", done_cnt, chk_cnt, bus.error);
        end
    endtask

    task automatic test_odd_header();
        clear_mon();
        wq = '{16'hB528, 16'hFD2F, 16'hAA01, 16'h5311, 16'h0000, 16'h997A};
        wait_done(200);
        checks++;
        if (hp_start_cnt !== 1 || hp_data_seen !== 16'hAA01) begin
            errors++;
            $display("FAIL odd_hp_start: got count %0d data %h expected 1 / AA01", hp_start_cnt, hp_data_seen);
        end
        checks++;
        if (blk_cnt !== 1 || blk_seen !== {21'd10, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL odd_blk_info: got count %0d info %h expected 1 / %h", blk_cnt, blk_seen, {21'd10, 2'd1, 1'b1});
        end
        checks++;
        if (got_bytes.size() != 1 || got_bytes[0] !== 8'h7A) begin
            errors++;
            $display("FAIL odd_rle_byte: got %0d bytes first %h expected 1 byte 7A", got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'h00);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL odd_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_checksum();
        clear_mon();
        wq = '{16'hB528, 16'hFD2F, 16'h0024, 16'h0001, 16'hEF00, 16'hADBE, 16'h77DE};
        wait_done(200);
        checks++;
        if (blk_cnt !== 1 || blk_seen !== {21'd0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL chk_blk_info: got count %0d info %h expected 1 / 000001", blk_cnt, blk_seen);
        end
        checks++;
        if (got_bytes.size() != 0) begin
            errors++;
            $display("FAIL chk_no_payload: got %0d bytes expected 0", got_bytes.size());
        end
        checks++;
        if (chk_cnt !== 1 || chk_seen !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL chk_value: got count %0d value %h expected 1 / DEADBEEF", chk_cnt, chk_seen);
        end
        checks++;
        if (done_cnt !== 1 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL chk_done: got done %0d error %b expected 1 / 0", done_cnt, bus.error);
        end
    endtask

    task automatic test_bad_magic();
        do_reset();
        wq = '{16'h1234, 16'hB528, 16'hFD2F};
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || bus.err_code !== 3'd1) begin
            errors++;
            $display("FAIL magic_error: got error %b code %0d expected 1 / 1", bus.error, bus.err_code);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.in_valid !== 1'b1) begin
            errors++;
            $display("FAIL magic_in_ready: got in_ready %b (in_valid %b) expected 0 with pending words", bus.in_ready, bus.in_valid);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b0 || bus.err_code !== 3'd0) begin
            errors++;
            $display("FAIL magic_reset_clears: got error %b code %0d expected 0 / 0", bus.error, bus.err_code);
        end
    endtask

    task automatic test_block_errors();
        do_reset();
        wq = '{16'hB528, 16'hFD2F, 16'h0520, 16'h0006, 16'h0000};
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || bus.err_code !== 3'd3 || blk_cnt !== 0) begin
            errors++;
            $display("FAIL reserved_type: got error %b code %0d blk %0d expected 1 / 3 / 0", bus.error, bus.err_code, blk_cnt);
        end
        do_reset();
        wq = '{16'hB528, 16'hFD2F, 16'h0520, 16'h0009, 16'h0010};
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || bus.err_code !== 3'd4 || blk_cnt !== 0) begin
            errors++;
            $display("FAIL oversize_block: got error %b code %0d blk %0d expected 1 / 4 / 0", bus.error, bus.err_code, blk_cnt);
        end
        do_reset();
        wq = '{16'hB528, 16'hFD2F, 16'h0520, 16'h0000, 16'h5510};
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b0 || blk_cnt !== 1 || blk_seen !== {21'd131072, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL max_size_block: got error %b blk %0d info %h expected 0 / 1 / %h", bus.error, blk_cnt, blk_seen, {21'd131072, 2'd0, 1'b0});
        end
    endtask

    task automatic test_hdr_timeout();
        do_reset();
        hp_auto = 1'b0;
        wq = '{16'hB528, 16'hFD2F, 16'h0520};
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got error %b expected 0", bus.error);
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || bus.err_code !== 3'd2) begin
            errors++;
            $display("FAIL timeout_error: got error %b code %0d expected 1 / 2", bus.error, bus.err_code);
        end
        hp_auto = 1'b1;
    endtask

    task automatic test_random_backpressure();
        int bad = 0;
        do_reset();
        rand_rdy = 1'b1;
        push_big_frame();
        wait_done(4000);
        rand_rdy = 1'b0;
        checks++;
        if (blk_cnt !== 1 || blk_seen !== {21'd300, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL bp_blk_info: got count %0d info %h expected 1 / %h", blk_cnt, blk_seen, {21'd300, 2'd0, 1'b1});
        end
        if (got_bytes.size() != 300) bad = 1;
        else for (int i = 0; i < 300; i++) if (got_bytes[i] !== 8'((i * 37 + 11) % 256)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_payload: got %0d bytes (%0d wrong) expected 300 in order", got_bytes.size(), bad);
        end
        checks++;
        if (done_cnt !== 1 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: got done %0d error %b expected 1 / 0", done_cnt, bus.error);
        end
    endtask

    task automatic test_reset_mid_payload();
        do_reset();
        rand_rdy = 1'b1;
        push_big_frame();
        for (int i = 0; i < 2000 && got_bytes.size() < 50; i++) @(posedge clk);
        checks++;
        if (got_bytes.size() < 50) begin
            errors++;
            $display("FAIL midrst_progress: got %0d bytes expected at least 50", got_bytes.size());
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs !== 90'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 0", outs);
        end
        rand_rdy = 1'b0;
        wq.delete();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_raw_frame();
        test_odd_header();
        test_checksum();
        test_bad_magic();
        test_block_errors();
        test_hdr_timeout();
        test_random_backpressure();
        test_reset_mid_payload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/zstd_frame_sequencer.md
Name: zstd_frame_sequencer

Overview:
- Top-level frame controller for the Zstandard decompressor.
- Consumes the compressed 16-bit word stream and checks the frame magic number.
- Drives Header_Parser (start pulse plus word feed), waits for its finished, then walks the block headers.
- Hands each block's header and payload bytes to the downstream block decoder, and captures the optional content checksum.

Parameters:
MAX_BLOCK_SIZE, 131072, largest legal Block_Size in bytes; larger is a frame error
HDR_TIMEOUT, 64, cycles to wait for hp_finished after the last header word before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_data  in  16  compressed stream word; byte0 = [7:0], byte1 = [15:8] (little-endian)
in_valid  in  1  in_data valid
in_ready  out  1  word accepted when in_valid && in_ready
hp_start  out  1  one-cycle start to Header_Parser, coincident with the first header word
hp_data  out  16  word feed to Header_Parser
hp_finished  in  1  Header_Parser done
out_byte  out  8  block payload byte
out_valid  out  1  payload byte valid
out_ready  in  1  downstream accepts payload byte
blk_valid  out  1  block header info valid; held until blk_ready
blk_ready  in  1  downstream accepts block header info
blk_type  out  2  0 raw, 1 RLE, 2 compressed
blk_size  out  21  Block_Size field
blk_last  out  1  Last_Block bit
chk_valid  out  1  one-cycle pulse; chk_value valid
chk_value  out  32  content checksum, little-endian assembled
frame_done  out  1  one-cycle pulse at end of frame
error  out  1  sticky until reset
err_code  out  3  1 bad magic, 2 header timeout, 3 reserved block type, 4 oversize block

Behaviour:
- Reset: all outputs 0, state IDLE, residue byte empty, all counters 0.
- Reset mid-frame aborts immediately; no partial pulses are emitted.
- States: IDLE, MAGIC, HDR, HDR_WAIT, BHDR, PAYLOAD, CHK, DONE, ERR.
- IDLE/MAGIC (in_ready=1):
  - Word 0 must equal 0xB528; word 1 must equal 0xFD2F.
  - Any mismatch -> ERR, code 1.
- HDR (in_ready=1; the parser has no backpressure):
  - hp_data = in_data combinationally.
  - hp_start = 1 on the first accepted header word only.
  - Header length L is computed from FHD = byte0 of the first header word:
    - L = 1 + (SS ? 0 : 1) + DID{0,1,2,4}[FHD[1:0]] + FCS size.
    - FCS size: flag 0 -> SS ? 1 : 0; flag 1 -> 2; flag 2 -> 4; flag 3 -> 8.
    - SS = FHD[5]; FCS flag = FHD[7:6].
  - Latch checksum_flag = FHD[2].
  - Accept ceil(L/2) words.
  - If L is odd, byte1 of the last header word goes into the residue register as the first block-header byte.
- HDR_WAIT: in_ready=0. On hp_finished -> BHDR. After HDR_TIMEOUT cycles without it -> ERR, code 2.
- Byte fetch, used by BHDR/PAYLOAD/CHK:
  - Take the residue byte if present; otherwise accept a word, use byte0, store byte1 in the residue.
  - in_ready=1 only when a byte is needed and the residue is empty.
- BHDR:
  - Collect 3 bytes into h[23:0]: blk_last = h[0], blk_type = h[2:1], blk_size = h[23:3].
  - Type 3 -> ERR, code 3.
  - blk_size > MAX_BLOCK_SIZE -> ERR, code 4. Checked before blk_valid is raised.
  - Otherwise assert blk_valid and hold it until blk_ready, then go to PAYLOAD.
- PAYLOAD:
  - Emit N bytes: N = blk_size for raw/compressed, N = 1 for RLE.
  - Hold out_byte stable while out_valid && !out_ready.
  - 21-bit down-counter; N = 0 skips PAYLOAD with no out_valid.
  - Blocks are back-to-back; no idle cycle is required between them.
  - At N done: if !blk_last -> BHDR; else if checksum_flag -> CHK; else DONE.
- CHK: fetch 4 bytes; chk_value = {b3,b2,b1,b0}; pulse chk_valid; -> DONE.
- DONE:
  - Pulse frame_done for one cycle and clear the residue.
  - A leftover residue byte is discarded; frames start word-aligned.
  - -> IDLE.
- ERR: in_ready=0, out_valid=0, blk_valid=0; error=1 until reset.

Decomposition:
- zstd_pkg holds:
  - ZSTD_MAGIC_LO = 16'hB528, ZSTD_MAGIC_HI = 16'hFD2F.
  - blk_type_e (RAW, RLE, COMPRESSED, RESERVED).
  - err_code_e.
  - seq_state_e.
  - function fhd_header_len(FHD) -> 4-bit length.
- One sub-module: zstd_byte_unpacker (16->8 with one-byte residue, byte_req/byte_valid handshake, flush input). The sequencer FSM sits on top of it.

Test Plan:
- Magic 0xB528,0xFD2F; header 0x0520 (FHD 0x20, FCS 5; L=2, even); hp_finished 3 cycles later; words 0x0029,0x4100,0x4342,0x4544 -> hp_start once with 0x0520; blk raw/size5/last; bytes 41 42 43 44 45; frame_done, no chk_valid.
- Odd header: FHD 0x01 (window+dict, L=3): words 0xAA01, 0x5311 (dict 0x11, block byte 0x53), then 0x0000, 0x??7A -> RLE size 10 last; single out_byte 0x7A; frame_done.
- Checksum: FHD 0x24, header word 0x0024, block word 0x0001, then byte 0x00 + checksum EF BE AD DE -> blk raw size0 last, no out_valid; chk_value 0xDEADBEEF; frame_done.
- First word 0x1234 -> error=1, err_code=1, in_ready=0 thereafter; reset clears.
- Block header bytes 06 00 00 -> err_code 3. Size 131073 -> err_code 4. hp_finished withheld 64 cycles -> err_code 2.
- Randomly toggle out_ready/blk_ready during a 300-byte raw block -> every byte exactly once, in order; then reset mid-payload -> all outputs 0 next cycle.
